// File: rtl/check_top.sv
// Three single-bit capture stages sharing one clock, enable and reset scheme:
// a plain enabled flop, a 2-deep clearable pipeline and an inverting presettable flop.
module check_top (
  input  logic clock,
  input  logic reset0,
  input  logic reset1,
  input  logic clock_en,
  input  logic in,
  output logic out0,
  output logic out1,
  output logic out2
);

  logic b1;

  // Stage A: enabled capture, deliberately blind to the functional clear.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values and the b1 -> out1 shift cannot collapse into one stage.
  always_ff @(posedge clock or negedge reset0) begin
    if (!reset0) begin
      out0 <= 1'b0;
    end else if (clock_en) begin
      out0 <= in;
    end
  end

  // Stage B: reset0 and reset1 both force the pipeline to zero.
  always_ff @(posedge clock or negedge reset0) begin
    if (!reset0) begin
      b1   <= 1'b0;
      out1 <= 1'b0;
    end else if (reset1) begin
      b1   <= 1'b0;
      out1 <= 1'b0;
    end else if (clock_en) begin
      b1   <= in;
      out1 <= b1;
    end
  end

  // Stage C: idles high, so both resets preset it to 1.
  always_ff @(posedge clock or negedge reset0) begin
    if (!reset0) begin
      out2 <= 1'b1;
    end else if (reset1) begin
      out2 <= 1'b1;
    end else if (clock_en) begin
      out2 <= ~in;
    end
  end

endmodule

// File: tb/tb_check_top.sv
// Self-checking bench for check_top: vector table with expected {out0,out1,out2}
// pushed to a scoreboard queue at drive time and popped after each rising edge.
module tb_check_top;

  logic clock = 1'b0;
  logic reset0, reset1, clock_en, in;
  logic out0, out1, out2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r1;
    logic       en;
    logic       d;
    logic [2:0] exp;  // {out0, out1, out2} after the edge
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[16];
  sb_t  sb_q[$];

  check_top dut (
    .clock    (clock),
    .reset0   (reset0),
    .reset1   (reset1),
    .clock_en (clock_en),
    .in       (in),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {out0,out1,out2}=%b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive at the falling edge, queue the expectation, compare 1 time unit after the rising edge.
  task automatic apply(input logic r1, input logic en, input logic d,
                       input logic [2:0] exp, input string name);
    sb_t e;
    @(negedge clock);
    reset1   = r1;
    clock_en = en;
    in       = d;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %b", name, {out0, out1, out2});
    end else begin
      e = sb_q.pop_front();
      check(e.name, {out0, out1, out2}, e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got none, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset-state walk from the cleared state: out0=0, b1=0, out1=0, out2=1.
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 3'b101};  // reset1 clears B/C, A still captures
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 3'b101};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 3'b101};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 3'b100};  // b1=1, out1 still 0
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 3'b110};  // out1 after 2nd edge
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 3'b011};  // b1=0, out1 still 1
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'b001};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'b100};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 3'b110};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'b110};  // enable low: hold while in toggles
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'b110};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3'b110};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 3'b110};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 3'b101};  // reset1 beats enable=0, out0 untouched
    vecs[14] = '{1'b0, 1'b1, 1'b1, 3'b100};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 3'b110};

    reset0   = 1'b1;
    reset1   = 1'b0;
    clock_en = 1'b1;
    in       = 1'b1;
    #1 reset0 = 1'b0;
    #1 check("reset_async", {out0, out1, out2}, 3'b001);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1 check($sformatf("reset_hold_edge%0d", i), {out0, out1, out2}, 3'b001);
      @(negedge clock);
      #2 check($sformatf("reset_hold_mid%0d", i), {out0, out1, out2}, 3'b001);
    end

    @(negedge clock);
    reset0 = 1'b1;
    for (int i = 0; i < 16; i++)
      apply(vecs[i].r1, vecs[i].en, vecs[i].d, vecs[i].exp, $sformatf("vec%0d", i));

    // A reset1 pulse entirely between edges must be ignored.
    @(negedge clock);
    reset1 = 1'b1;
    #2 reset1 = 1'b0;
    @(posedge clock);
    #1 check("reset1_between_edges", {out0, out1, out2}, 3'b110);

    // reset0 mid-cycle, with reset1 also high, forces outputs before the next edge.
    @(negedge clock);
    reset1 = 1'b1;
    #2 reset0 = 1'b0;
    #1 check("reset0_midcycle", {out0, out1, out2}, 3'b001);

    // First edges after release follow normal rules.
    @(negedge clock);
    reset0 = 1'b1;
    apply(1'b0, 1'b1, 1'b1, 3'b100, "post_reset_edge1");
    apply(1'b0, 1'b1, 1'b1, 3'b110, "post_reset_edge2");
    apply(1'b0, 1'b1, 1'b0, 3'b011, "post_reset_edge3");

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/check_top.md
CHECK_TOP -- requirements
Module: check_top

Interface
REQ-001 check_top SHALL have no parameters; all widths and depths are fixed.
REQ-002 Port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 Port reset0, input, 1 bit: block reset, asynchronous, active-low.
REQ-004 Port reset1, input, 1 bit: synchronous functional clear/preset, active-high; not a block reset.
REQ-005 Port clock_en, input, 1 bit: clock enable, active-high, gates normal data capture in all stages.
REQ-006 Port in, input, 1 bit: serial data input.
REQ-007 Port out0, output, 1 bit: asynchronously cleared, enabled capture of in.
REQ-008 Port out1, output, 1 bit: 2-stage enabled pipeline of in with synchronous clear.
REQ-009 Port out2, output, 1 bit: enabled capture of inverted in with synchronous preset.
REQ-010 All outputs SHALL be driven directly from flip-flops; no combinational input-to-output path.

Function
REQ-011 Stage A (out0): at a rising clock edge with clock_en=1, out0 <= in; with clock_en=0, out0 holds.
REQ-012 Stage A SHALL ignore reset1.
REQ-013 Stage B: two registers b1, b2 with out1=b2; at an edge with reset1=1, b1<=0 and b2<=0 regardless of clock_en.
REQ-014 Stage B: at an edge with reset1=0 and clock_en=1, b1<=in and b2<=b1; latency from in to out1 is 2 enabled edges.
REQ-015 Stage B: at an edge with reset1=0 and clock_en=0, b1 and b2 hold.
REQ-016 Stage C (out2): at an edge with reset1=1, out2<=1 regardless of clock_en.
REQ-017 Stage C: at an edge with reset1=0 and clock_en=1, out2<=~in; with clock_en=0, out2 holds.
REQ-018 Priority at each edge: reset0 low > reset1 high > clock_en > hold.
REQ-019 Output latency from in: out0 1 enabled edge, out1 2 enabled edges, out2 1 enabled edge.
REQ-020 reset1 SHALL act only at rising clock edges; toggling it between edges has no effect.
REQ-021 Identical stimulus to any two instances SHALL produce bit-identical outputs after the first post-reset edge.

Reset
REQ-022 While reset0=0, immediately and without a clock edge: out0=0, b1=0, out1=0, out2=1.
REQ-023 reset0 asserted mid-operation SHALL override pending data and reset1 immediately.
REQ-024 On reset0 deassertion, the first rising edge with reset0=1 SHALL apply normal REQ-011..REQ-018 rules.
REQ-025 Reset values SHALL equal the reset1 clear/preset values for stages B and C, so reset0 and reset1 yield the same out1/out2.

Verification
REQ-026 reset0=0 with clock running, in=1, clock_en=1 -> out0=0, out1=0, out2=1 continuously, including between edges.
REQ-027 reset0=1, reset1=1, in=1, clock_en=1 for 3 edges -> out0=1 after edge 1; out1=0 and out2=1 throughout.
REQ-028 reset0=1, reset1=0, clock_en=1, in=1 held -> out0=1 and out2=0 after edge 1; out1=0 after edge 1, out1=1 after edge 2.
REQ-029 From REQ-028 state, in=0 -> out0=0 and out2=1 after the next edge; out1=0 two edges after in changes.
REQ-030 clock_en=0, toggle in for 4 edges -> all outputs hold; then reset1=1 for 1 edge with clock_en=0 -> out1=0, out2=1, out0 unchanged.
REQ-031 Pull reset0=0 between edges while out0=1, out1=1, out2=0 -> outputs become 0, 0, 1 before the next edge.
